// File: rtl/i2c_config_sequencer.sv
// Power-up register loader for i2c_master: walks INIT_TABLE, issues one write per entry, handles delay entries and retries.
// Optional read-back verification of every write is enabled by defining CFG_READBACK_EN.
module i2c_config_sequencer #(
  parameter int                        NUM_ENTRIES = 8,
  parameter logic [NUM_ENTRIES*16-1:0] INIT_TABLE  = {8{16'h0000}},
  parameter logic [6:0]                SLAVE_ADDR  = 7'h3C,
  parameter int                        MAX_RETRIES = 3,
  parameter int                        DELAY_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] fail_index,
  output logic [6:0] slav_addr,
  output logic       read_not_write,
  output logic [7:0] reg_addr,
  output logic [7:0] write_data,
  output logic       write_valid,
  input  logic       write_ready,
  input  logic [7:0] read_data,
  input  logic       read_valid,
  output logic       read_ready,
  input  logic       error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_DELAY, S_WAIT, S_NEXT, S_DONE, S_FAIL
`ifdef CFG_READBACK_EN
    , S_RB_ISSUE, S_RB_WAIT
`endif
  } state_e;

  localparam logic [7:0] DELAY_REG  = 8'hFF;
  localparam logic [1:0] IGNORE_CYC = 2'd2;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] delay_cnt_q, delay_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic [7:0]  fail_index_q, fail_index_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  write_data_q, write_data_d;
  logic [15:0] entry;
  logic [31:0] delay_len;
  logic        take_retry;

  always_comb begin
    entry = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (idx_q == 8'(i)) entry = INIT_TABLE[16*i +: 16];
    end
  end

  assign delay_len = 32'(entry[7:0]) * 32'(DELAY_TICKS);

  // NOTE: every _d gets its default first, so no branch can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    wait_cnt_d   = wait_cnt_q;
    delay_cnt_d  = delay_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_index_d = fail_index_q;
    reg_addr_d   = reg_addr_q;
    write_data_d = write_data_q;
    take_retry   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          retry_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_LOAD: begin
        reg_addr_d   = entry[15:8];
        write_data_d = entry[7:0];
        if (entry[15:8] == DELAY_REG) begin
          state_d     = S_DELAY;
          delay_cnt_d = (delay_len == '0) ? '0 : delay_len - 32'd1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (write_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      // The master only drops write_ready a cycle after the handshake, so its early ready is stale.
      S_WAIT: begin
        if (error) begin
          take_retry = 1'b1;
        end else if (wait_cnt_q != IGNORE_CYC) begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end else if (write_ready) begin
`ifdef CFG_READBACK_EN
          state_d = S_RB_ISSUE;
`else
          state_d = S_NEXT;
`endif
        end
      end
`ifdef CFG_READBACK_EN
      S_RB_ISSUE: begin
        if (write_ready) begin
          state_d    = S_RB_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_RB_WAIT: begin
        if (error) begin
          take_retry = 1'b1;
        end else if (wait_cnt_q != IGNORE_CYC) begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end else if (read_valid) begin
          if (read_data == write_data_q) state_d = S_NEXT;
          else                           take_retry = 1'b1;
        end
      end
`endif
      S_DELAY: begin
        if (delay_cnt_q == '0) state_d = S_NEXT;
        else                   delay_cnt_d = delay_cnt_q - 32'd1;
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == 8'(NUM_ENTRIES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A failed attempt re-writes the same entry from scratch (and re-reads it when read-back is on).
    if (take_retry) begin
      if (retry_q < 8'(MAX_RETRIES)) begin
        retry_d = retry_q + 8'd1;
        state_d = S_ISSUE;
      end else begin
        state_d      = S_FAIL;
        fail_d       = 1'b1;
        fail_index_d = idx_q;
        busy_d       = 1'b0;
      end
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its _d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      retry_q      <= '0;
      wait_cnt_q   <= '0;
      delay_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_index_q <= '0;
      reg_addr_q   <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      wait_cnt_q   <= wait_cnt_d;
      delay_cnt_q  <= delay_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_index_q <= fail_index_d;
      reg_addr_q   <= reg_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_index = fail_index_q;
  assign slav_addr  = SLAVE_ADDR;
  assign reg_addr   = reg_addr_q;
  assign write_data = write_data_q;

`ifdef CFG_READBACK_EN
  assign write_valid    = (state_q == S_ISSUE) || (state_q == S_RB_ISSUE);
  assign read_not_write = (state_q == S_RB_ISSUE) || (state_q == S_RB_WAIT);
  assign read_ready     = (state_q == S_RB_WAIT) && (wait_cnt_q == IGNORE_CYC) && read_valid && !error;
`else
  assign write_valid    = (state_q == S_ISSUE);
  assign read_not_write = 1'b0;
  assign read_ready     = 1'b0;

  logic unused_read_path;
  assign unused_read_path = ^{read_data, read_valid};
`endif

endmodule
